// File: rtl/banner_scroll_ctrl.sv
// Banner sequencer: decodes UART bytes into digit codes, buffers a message and
// scrolls a 6-digit window over it for LED_mux (in5 leftmost, in0 rightmost).
module banner_scroll_ctrl #(
    parameter int          TURNS      = 25_000_000,
    parameter int          DEPTH      = 32,
    parameter logic [4:0]  BLANK_CODE = 5'd16,
    parameter logic [4:0]  DASH_CODE  = 5'd17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    output logic [4:0] in0,
    output logic [4:0] in1,
    output logic [4:0] in2,
    output logic [4:0] in3,
    output logic [4:0] in4,
    output logic [4:0] in5,
    output logic       scrolling,
    output logic       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TURNS);
    localparam logic [AW:0]   LEN_FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TURNS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCROLL, S_PAUSE} state_t;

    state_t          state_q, state_d;
    logic [AW:0]     len_q, len_d;
    logic [AW-1:0]   pos_q, pos_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dir_q, dir_d;  // 0 = left, 1 = right
    logic            ovf_q, ovf_d;
    logic [4:0]      msg_q [DEPTH];
    logic [5:0][4:0] win_q, win_d;

    logic            is_data, is_cr, is_p, is_lt, is_gt;
    logic [4:0]      code;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [AW:0]     len_m1;

    always_comb begin
        is_data = 1'b0;
        code    = BLANK_CODE;
        if (rx_data inside {[8'h30:8'h39]}) begin
            is_data = 1'b1;
            code    = {1'b0, rx_data[3:0]};
        end else if (rx_data inside {[8'h41:8'h46], [8'h61:8'h66]}) begin
            is_data = 1'b1;
            code    = 5'(rx_data[2:0]) + 5'd9;
        end else if (rx_data == 8'h20) begin
            is_data = 1'b1;
        end else if (rx_data == 8'h2D) begin
            is_data = 1'b1;
            code    = DASH_CODE;
        end
        is_data = is_data && rx_done_tick;
        is_cr   = rx_done_tick && (rx_data == 8'h0D);
        is_p    = rx_done_tick && (rx_data == 8'h50 || rx_data == 8'h70);
        is_lt   = rx_done_tick && (rx_data == 8'h3C);
        is_gt   = rx_done_tick && (rx_data == 8'h3E);
    end

    assign len_m1 = len_q - 1'b1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        waddr   = '0;
        if (is_lt) dir_d = 1'b0;
        if (is_gt) dir_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (is_data) begin
                    we      = 1'b1;
                    len_d   = (AW+1)'(1);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (is_data) begin
                    if (len_q == LEN_FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        we    = 1'b1;
                        waddr = len_q[AW-1:0];
                        len_d = len_q + 1'b1;
                    end
                end else if (is_cr) begin
                    pos_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SCROLL;
                end
            end
            S_SCROLL, S_PAUSE: begin
                if (is_data) begin
                    we      = 1'b1;
                    len_d   = (AW+1)'(1);
                    ovf_d   = 1'b0;
                    state_d = S_LOAD;
                end else if (is_p) begin
                    state_d = (state_q == S_SCROLL) ? S_PAUSE : S_SCROLL;
                end else if (state_q == S_SCROLL) begin
                    // step uses dir_q, so a same-cycle '<'/'>' only affects later steps
                    if (cnt_q == CNT_MAX) begin
                        cnt_d = '0;
                        if (!dir_q)
                            pos_d = ({1'b0, pos_q} == len_m1) ? '0 : pos_q + 1'b1;
                        else
                            pos_d = (pos_q == '0) ? len_m1[AW-1:0] : pos_q - 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        logic [AW:0] idx;
        win_d = {6{BLANK_CODE}};
        for (int k = 0; k < 6; k++) begin
            idx = {1'b0, pos_q} + (AW+1)'(k);
            if (idx >= len_q) idx = idx - len_q;
            if ((state_q == S_SCROLL || state_q == S_PAUSE) && idx < len_q)
                win_d[k] = msg_q[idx[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            ovf_q   <= 1'b0;
            win_q   <= {6{BLANK_CODE}};
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            ovf_q   <= ovf_d;
            win_q   <= win_d;
        end
    end

    // Message storage needs no reset: it is always rewritten before display.
    always_ff @(posedge clk) begin
        if (we && !rst) msg_q[waddr] <= code;
    end

    assign in5       = win_q[0];
    assign in4       = win_q[1];
    assign in3       = win_q[2];
    assign in2       = win_q[3];
    assign in1       = win_q[4];
    assign in0       = win_q[5];
    assign scrolling = (state_q == S_SCROLL);
    assign overflow  = ovf_q;
endmodule
